// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: two-byte read/write command layer on top of an SPI slave.
// Decodes command bytes, owns a small register bank and chooses the byte
// returned to the SPI master on the next transaction.
module spi_reg_bridge #(
  parameter int unsigned NREGS   = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               busy,
  input  logic [7:0]         rx_byte,
  output logic [7:0]         tx_byte,
  input  logic [7:0]         status_in,
  output logic [NREGS*8-1:0] regs_flat,
  output logic               wr_strobe,
  output logic [2:0]         wr_addr,
  output logic               err
);

  localparam int unsigned AW    = 3;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0]    SYNC_MARK   = 4'b1010;
  localparam logic [7:0]    TX_IDLE     = 8'hA5;
  localparam logic [7:0]    TX_ERR      = 8'hEE;
  localparam logic [7:0]    TX_WACK     = 8'h00;
  localparam logic [AW-1:0] STATUS_ADDR = AW'(NREGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic               busy_d;
  logic               byte_done;
  logic [AW-1:0]      addr_q, addr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               timeout_hit;
  logic [7:0]         tx_n;
  logic [NREGS*8-1:0] regs_n;
  logic               wr_strobe_n;
  logic [AW-1:0]      wr_addr_n;
  logic               err_n;

  logic               cmd_write;
  logic [3:0]         cmd_sync;
  logic [AW-1:0]      cmd_addr;
  logic [7:0]         rd_data;

  // Falling edge of busy marks a completed byte
  assign byte_done   = busy_d & ~busy;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Command byte fields and the read-back value they select
  assign cmd_write = rx_byte[7];
  assign cmd_sync  = rx_byte[6:3];
  assign cmd_addr  = rx_byte[2:0];
  assign rd_data   = (cmd_addr == STATUS_ADDR) ? status_in
                                               : regs_flat[{cmd_addr, 3'b000} +: 8];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_d    <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      tx_byte   <= TX_IDLE;
      regs_flat <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err       <= 1'b0;
    end else begin
      busy_d    <= busy;
      addr_q    <= addr_n;
      cnt_q     <= cnt_n;
      tx_byte   <= tx_n;
      regs_flat <= regs_n;
      wr_strobe <= wr_strobe_n;
      wr_addr   <= wr_addr_n;
      err       <= err_n;
    end
  end

  // Next-state and next-output decode; byte_done takes priority over timeout
  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    cnt_n       = cnt_q;
    tx_n        = tx_byte;
    regs_n      = regs_flat;
    wr_strobe_n = 1'b0;
    wr_addr_n   = wr_addr;
    err_n       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (byte_done) begin
          if ((cmd_sync != SYNC_MARK) || (cmd_write && (cmd_addr == STATUS_ADDR))) begin
            err_n = 1'b1;
            tx_n  = TX_ERR;
          end else if (cmd_write) begin
            addr_n  = cmd_addr;
            tx_n    = TX_WACK;
            state_n = WDATA;
          end else begin
            addr_n  = cmd_addr;
            tx_n    = rd_data;
            state_n = RDATA;
          end
        end
      end

      WDATA: begin
        if (byte_done) begin
          regs_n[{addr_q, 3'b000} +: 8] = rx_byte;
          wr_strobe_n = 1'b1;
          wr_addr_n   = addr_q;
          tx_n        = rx_byte;
          state_n     = IDLE;
        end else if (timeout_hit) begin
          err_n   = 1'b1;
          tx_n    = TX_IDLE;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      RDATA: begin
        if (byte_done) begin
          tx_n    = TX_IDLE;
          state_n = IDLE;
        end else if (timeout_hit) begin
          err_n   = 1'b1;
          tx_n    = TX_IDLE;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    // The status slot is never backed by storage
    regs_n[(NREGS-1)*8 +: 8] = 8'h00;
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed protocol cases plus randomized byte
// streams, all checked every cycle against a transaction-level model.
module tb_spi_reg_bridge;

  localparam int unsigned NREGS   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               busy = 1'b0;
  logic [7:0]         rx_byte = 8'h00;
  logic [7:0]         tx_byte;
  logic [7:0]         status_in = 8'h00;
  logic [NREGS*8-1:0] regs_flat;
  logic               wr_strobe;
  logic [2:0]         wr_addr;
  logic               err;

  spi_reg_bridge #(.NREGS(NREGS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .rx_byte   (rx_byte),
    .tx_byte   (tx_byte),
    .status_in (status_in),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: register contents, the reply byte, and the open frame
  logic [7:0] m_regs [NREGS];
  logic [7:0] m_tx;
  logic       m_stb;
  logic       m_err;
  logic [2:0] m_wa;
  int         pend;     // 0 = no open frame, 1 = awaiting write data, 2 = awaiting read dummy
  int         pa;       // address of the open frame
  int         elapsed;  // clock edges spent waiting for the second byte

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_flat();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < NREGS - 1; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_tx = 8'hA5; m_stb = 1'b0; m_err = 1'b0; m_wa = 3'd0;
    pend = 0; pa = 0; elapsed = 0;
  endtask

  // Effect of one completed byte on the model
  task automatic model_byte(input logic [7:0] b);
    logic [3:0] mark;
    logic [2:0] a;
    mark = b[6:3];
    a    = b[2:0];
    if (pend == 1) begin
      m_regs[pa] = b; m_stb = 1'b1; m_wa = 3'(pa); m_tx = b; pend = 0;
    end else if (pend == 2) begin
      m_tx = 8'hA5; pend = 0;
    end else if (mark != 4'b1010 || (b[7] && a == 3'd7)) begin
      m_err = 1'b1; m_tx = 8'hEE;
    end else if (b[7]) begin
      m_tx = 8'h00; pend = 1; pa = int'(a); elapsed = 0;
    end else begin
      m_tx = (a == 3'd7) ? status_in : m_regs[a];
      pend = 2; pa = int'(a); elapsed = 0;
    end
  endtask

  // Advance one clock; ev marks the edge on which a byte completes
  task automatic tick(input bit ev, input logic [7:0] b);
    @(posedge clk); #1;
    m_stb = 1'b0; m_err = 1'b0;
    if (ev) model_byte(b);
    else if (pend != 0) begin
      elapsed++;
      if (elapsed == TIMEOUT) begin
        m_err = 1'b1; m_tx = 8'hA5; pend = 0;
      end
    end
    check("tx_byte",   64'(tx_byte),   64'(m_tx));
    check("err",       64'(err),       64'(m_err));
    check("wr_strobe", 64'(wr_strobe), 64'(m_stb));
    check("wr_addr",   64'(wr_addr),   64'(m_wa));
    check("regs_flat", regs_flat,      exp_flat());
  endtask

  // g idle cycles, then busy high for h cycles with junk on rx_byte, then byte b
  task automatic send_byte(input logic [7:0] b, input int g, input int h);
    repeat (g) tick(1'b0, 8'h00);
    busy = 1'b1;
    rx_byte = 8'($urandom);
    repeat (h) tick(1'b0, 8'h00);
    busy = 1'b0;
    rx_byte = b;
    tick(1'b1, b);
  endtask

  task automatic do_reset();
    rst = 1'b1; busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    repeat (10) tick(1'b0, 8'h00);

    // Write then read back register 2
    send_byte(8'hD2, 2, 2);
    send_byte(8'h3C, 1, 1);
    send_byte(8'h52, 0, 2);
    send_byte(8'h00, 1, 1);

    // Status read, and the rejected write to the status slot
    status_in = 8'h81;
    send_byte(8'h57, 0, 1);
    send_byte(8'h00, 0, 1);
    send_byte(8'hD7, 0, 1);

    // Bad marker, then a valid read of register 0
    send_byte(8'h12, 0, 1);
    send_byte(8'h50, 0, 1);
    send_byte(8'h00, 0, 1);

    // Frame abandoned after TIMEOUT silent cycles, next byte is a command
    send_byte(8'hD1, 0, 1);
    repeat (20) tick(1'b0, 8'h00);
    send_byte(8'h51, 0, 1);
    send_byte(8'h00, 0, 1);

    // Data byte landing on the final allowed edge still wins
    send_byte(8'hD1, 0, 1);
    send_byte(8'h77, 14, 1);
    // One edge later it is too late
    send_byte(8'hD3, 0, 1);
    send_byte(8'h44, 15, 1);

    // Reset between command and data clears the bank and the open frame
    send_byte(8'hD4, 0, 1);
    do_reset();
    repeat (3) tick(1'b0, 8'h00);
    send_byte(8'h3C, 0, 1);
    send_byte(8'h50, 0, 1);
    send_byte(8'h00, 0, 1);

    // Randomized byte streams
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int g;
      if ($urandom_range(0, 3) != 0) b = {1'($urandom), 4'b1010, 3'($urandom)};
      else                           b = 8'($urandom);
      g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20))
                                      : int'($urandom_range(0, 3));
      status_in = 8'($urandom);
      send_byte(b, g, int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
